// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings, default
// latencies and FSM states, also used by the decoder and hazard unit.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU with a fixed
// multi-cycle latency and serves MTHI/MTLO writes and MFHI/MFLO reads.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rd_hi,
  output logic        busy,
  output logic        active,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] a_abs, b_abs, q_mag, r_mag, q_u, r_u;
  logic [63:0] result;
  logic        result_valid;

  // Signed division is done on magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    a_abs = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_abs = b_q[31] ? (~b_q + 32'd1) : b_q;
    q_mag = (b_abs != 32'd0) ? (a_abs / b_abs) : 32'd0;
    r_mag = (b_abs != 32'd0) ? (a_abs % b_abs) : 32'd0;
    q_u   = (b_q != 32'd0) ? (a_q / b_q) : 32'd0;
    r_u   = (b_q != 32'd0) ? (a_q % b_q) : 32'd0;
    result       = 64'd0;
    result_valid = 1'b1;
    case (op_q)
      MD_MULT:  result = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      MD_MULTU: result = {32'd0, a_q} * {32'd0, b_q};
      MD_DIV: begin
        result[31:0]  = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
        result[63:32] = a_q[31] ? (~r_mag + 32'd1) : r_mag;
        result_valid  = (b_q != 32'd0);
      end
      MD_DIVU: begin
        result       = {r_u, q_u};
        result_valid = (b_q != 32'd0);
      end
      default: result_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d = ST_BUSY;
              cnt_d   = (md_op == MD_DIV || md_op == MD_DIVU) ? DIV_CNT : MUL_CNT;
              op_d    = md_op;
              a_d     = rs_data;
              b_d     = rt_data;
            end
            MD_MTHI: hi_d = rs_data;
            MD_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (result_valid) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == ST_BUSY);
  assign active  = start | busy;
  assign rd_data = rd_hi ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, rd_hi;
  logic [2:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        busy, active;
  logic [31:0] rd_data, hi, lo;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .rd_hi(rd_hi),
    .busy(busy), .active(active), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural effect of one op on HI/LO.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] pu;
    case (op)
      MD_MULT: begin
        p = longint'(int'(a)) * longint'(int'(b));
        {exp_hi, exp_lo} = 64'(p);
      end
      MD_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        {exp_hi, exp_lo} = pu;
      end
      MD_DIV: if (b != 32'd0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          exp_lo = a;
          exp_hi = 32'd0;
        end else begin
          exp_lo = 32'(int'(a) / int'(b));
          exp_hi = 32'(int'(a) % int'(b));
        end
      end
      MD_DIVU: if (b != 32'd0) begin
        exp_lo = a / b;
        exp_hi = a % b;
      end
      MD_MTHI: exp_hi = a;
      MD_MTLO: exp_lo = a;
      default: ;
    endcase
  endfunction

  // Drive a one-cycle start pulse; returns #1 after the launching edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(posedge clk);
    #1;
    start = 1'b0; md_op = MD_NONE; rs_data = $urandom; rt_data = $urandom;
  endtask

  // Counts consecutive busy cycles (bounded); ends at a negedge with busy low.
  task automatic count_busy(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; rs_data = '0; rt_data = '0; rd_hi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset must beat a simultaneous MTHI
    start = 1'b1; md_op = MD_MTHI; rs_data = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; md_op = MD_NONE;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b want 0", active); end
    $display("txn reset: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_mult;
    int n;
    launch(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    model(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    rd_hi = 1'b0;
    #1;
    checks++; if (rd_data !== 32'd0) begin fails++; $display("FAIL mult_old_lo: got %h want 0", rd_data); end
    count_busy(n);
    checks++; if (n !== 5) begin fails++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      fails++; $display("FAIL mult_result: got %h_%h want ffffffff_fffffff1", hi, lo); end
    $display("txn MULT -3*5: hi=%h lo=%h busy_cycles=%0d", hi, lo, n);
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    model(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    checks++; if (n !== 5) begin fails++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    checks++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL multu_result: got %h_%h want 00000001_fffffffe", hi, lo); end
    $display("txn MULTU ffffffff*2: hi=%h lo=%h busy_cycles=%0d", hi, lo, n);
  endtask

  task automatic test_div;
    int n;
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    model(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++; if (n !== 10) begin fails++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      fails++; $display("FAIL div_result: got %h_%h want ffffffff_fffffffd", hi, lo); end
    $display("txn DIV -7/2: hi=%h lo=%h busy_cycles=%0d", hi, lo, n);
    launch(MD_DIVU, 32'd7, 32'd0);
    count_busy(n);
    checks++; if (n !== 10) begin fails++; $display("FAIL divu0_busy_cycles: got %0d want 10", n); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      fails++; $display("FAIL divu0_unchanged: got %h_%h want ffffffff_fffffffd", hi, lo); end
    $display("txn DIVU 7/0: hi=%h lo=%h busy_cycles=%0d", hi, lo, n);
    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    model(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    checks++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      fails++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", hi, lo); end
    $display("txn DIV 80000000/-1: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_mt;
    @(negedge clk);
    start = 1'b1; md_op = MD_MTHI; rs_data = 32'h1234_5678;
    #1;
    checks++; if (active !== 1'b1) begin fails++; $display("FAIL mt_active: got %b want 1", active); end
    @(posedge clk);
    #1;
    start = 1'b0; md_op = MD_NONE;
    model(MD_MTHI, 32'h1234_5678, 32'd0);
    @(negedge clk);
    checks++; if (hi !== 32'h1234_5678) begin fails++; $display("FAIL mthi_value: got %h want 12345678", hi); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy: got %b want 0", busy); end
    rd_hi = 1'b1;
    #1;
    checks++; if (rd_data !== 32'h1234_5678) begin fails++; $display("FAIL mfhi: got %h want 12345678", rd_data); end
    rd_hi = 1'b0;
    #1;
    checks++; if (rd_data !== exp_lo) begin fails++; $display("FAIL mflo: got %h want %h", rd_data, exp_lo); end
    $display("txn MTHI 12345678: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back;
    int n;
    launch(MD_MULT, 32'h0000_1234, 32'h0000_0010);
    model(MD_MULT, 32'h0000_1234, 32'h0000_0010);
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT; rs_data = 32'd7; rt_data = 32'd7;
    @(posedge clk);
    #1;
    md_op = MD_MTLO; rs_data = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    start = 1'b0; md_op = MD_NONE;
    checks++; if (lo === 32'h0000_ABCD) begin fails++; $display("FAIL ignored_mtlo: got %h want not 0000abcd", lo); end
    count_busy(n);
    checks++; if (n !== 3) begin fails++; $display("FAIL ignored_start_schedule: got %0d remaining want 3", n); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin
      fails++; $display("FAIL ignored_start_result: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
    $display("txn MULT with ignored starts: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset_mid;
    launch(MD_MTLO, 32'h5555_AAAA, 32'd0);
    launch(MD_DIV, 32'd1000, 32'd3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
      fails++; $display("FAIL midreset_clear: got %h_%h want 0_0", hi, lo); end
    repeat (12) @(negedge clk);
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
      fails++; $display("FAIL midreset_late_write: got %h_%h want 0_0", hi, lo); end
    $display("txn DIV aborted by reset: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_random;
    int n, want_n;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int t = 0; t < 30; t++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'(($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      want_n = (op == MD_MULT || op == MD_MULTU) ? 5 : (op == MD_DIV || op == MD_DIVU) ? 10 : 0;
      launch(op, a, b);
      model(op, a, b);
      count_busy(n);
      checks++; if (n !== want_n) begin fails++; $display("FAIL rand_busy op=%0d: got %0d want %0d", op, n, want_n); end
      checks++; if (hi !== exp_hi || lo !== exp_lo) begin
        fails++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h_%h want %h_%h", op, a, b, hi, lo, exp_hi, exp_lo); end
      $display("txn rand op=%0d a=%h b=%h: hi=%h lo=%h busy_cycles=%0d", op, a, b, hi, lo, n);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mt;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
